// File: rtl/mem_load_unit.sv
// Memory-stage load responder: issues one SRAM word read per load, aligns/extends/merges
// the returned word and presents a single writeback beat. Optional macro: LOAD_ADDR_EXC_EN.
module mem_load_unit #(
    parameter int REG_ADDR_W  = 6,
    parameter int LOAD_TYPE_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   exe_valid,
    output logic                   ld_ready,
    input  logic                   exe_mem_read,
    input  logic [LOAD_TYPE_W-1:0] exe_load_type,
    input  logic [31:0]            exe_addr,
    input  logic [31:0]            exe_load_rt_data,
    input  logic                   exe_reg_en,
    input  logic [REG_ADDR_W-1:0]  exe_reg_waddr,
    output logic                   data_req,
    output logic [31:0]            data_addr,
    input  logic                   data_addr_ok,
    input  logic                   data_rvalid,
    input  logic [31:0]            data_rdata,
    output logic                   wb_valid,
    output logic                   wb_reg_en,
    output logic [REG_ADDR_W-1:0]  wb_reg_waddr,
    output logic [31:0]            wb_rdata,
    output logic                   wb_addr_err,
    output logic                   mem_busy
);

    localparam logic [LOAD_TYPE_W-1:0] LT_LB  = LOAD_TYPE_W'(1);
    localparam logic [LOAD_TYPE_W-1:0] LT_LBU = LOAD_TYPE_W'(2);
    localparam logic [LOAD_TYPE_W-1:0] LT_LH  = LOAD_TYPE_W'(3);
    localparam logic [LOAD_TYPE_W-1:0] LT_LHU = LOAD_TYPE_W'(4);
    localparam logic [LOAD_TYPE_W-1:0] LT_LWL = LOAD_TYPE_W'(5);
    localparam logic [LOAD_TYPE_W-1:0] LT_LWR = LOAD_TYPE_W'(6);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                  state, state_nx;
    logic                    accept;
    logic                    capture;
    logic                    misalign;
    logic                    err_q;
    logic [LOAD_TYPE_W-1:0]  lt_q;
    logic [1:0]              off_q;
    logic [31:0]             rt_q;
    logic                    reg_en_q;
    logic [REG_ADDR_W-1:0]   waddr_q;

    // Handshake: a bundle transfers on a cycle where exe_valid && ld_ready; ld_ready is
    // high only in IDLE, and every bundle field is captured on that same edge.
    assign ld_ready = (state == IDLE);
    assign accept   = exe_valid && ld_ready;
    assign data_req = (state == REQ);
    assign wb_valid = (state == DONE);
    assign mem_busy = (state != IDLE);
    assign wb_addr_err = err_q;

    assign capture = ((state == REQ) && data_addr_ok && data_rvalid) ||
                     ((state == WAIT) && data_rvalid);

`ifdef LOAD_ADDR_EXC_EN
    always_comb begin
        misalign = 1'b0;
        if (exe_mem_read) begin
            case (exe_load_type)
                LT_LH, LT_LHU:                 misalign = exe_addr[0];
                LT_LB, LT_LBU, LT_LWL, LT_LWR: misalign = 1'b0;
                default:                       misalign = |exe_addr[1:0];
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    function automatic logic [31:0] align_load(input logic [LOAD_TYPE_W-1:0] lt,
                                               input logic [1:0] a,
                                               input logic [31:0] m,
                                               input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = m[{a, 3'b000} +: 8];
        h   = m[{a[1], 4'b0000} +: 16];
        res = m;
        case (lt)
            LT_LB:  res = {{24{b[7]}}, b};
            LT_LBU: res = {24'h0, b};
            LT_LH:  res = {{16{h[15]}}, h};
            LT_LHU: res = {16'h0, h};
            LT_LWL: begin
                case (a)
                    2'd0:    res = {m[7:0],  r[23:0]};
                    2'd1:    res = {m[15:0], r[15:0]};
                    2'd2:    res = {m[23:0], r[7:0]};
                    default: res = m;
                endcase
            end
            LT_LWR: begin
                case (a)
                    2'd0:    res = m;
                    2'd1:    res = {r[31:24], m[31:8]};
                    2'd2:    res = {r[31:16], m[31:16]};
                    default: res = {r[31:8],  m[31:24]};
                endcase
            end
            default: res = m;
        endcase
        return res;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (!exe_mem_read || misalign) ? DONE : REQ;
                end
            end
            // rvalid without addr_ok in REQ is not a response to this request
            REQ: begin
                if (data_addr_ok && data_rvalid) begin
                    state_nx = DONE;
                end else if (data_addr_ok) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            data_addr    <= 32'h0;
            wb_reg_en    <= 1'b0;
            wb_reg_waddr <= '0;
            wb_rdata     <= 32'h0;
            err_q        <= 1'b0;
            lt_q         <= '0;
            off_q        <= 2'b00;
            rt_q         <= 32'h0;
            reg_en_q     <= 1'b0;
            waddr_q      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lt_q     <= exe_load_type;
                off_q    <= exe_addr[1:0];
                rt_q     <= exe_load_rt_data;
                reg_en_q <= exe_reg_en;
                waddr_q  <= exe_reg_waddr;
                if (!exe_mem_read || misalign) begin
                    // passthrough, or the faulting address reported as BadVAddr
                    wb_rdata     <= exe_addr;
                    wb_reg_en    <= exe_reg_en && !misalign;
                    wb_reg_waddr <= exe_reg_waddr;
                    err_q        <= misalign;
                end else begin
                    data_addr <= {exe_addr[31:2], 2'b00};
                end
            end
            if (capture) begin
                wb_rdata     <= align_load(lt_q, off_q, data_rdata, rt_q);
                wb_reg_en    <= reg_en_q;
                wb_reg_waddr <= waddr_q;
                err_q        <= 1'b0;
            end
        end
    end

endmodule
